// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I operand select/forward and ALU opcode encode, feeding the ALU
// through a 2-entry skid buffer so in_ready never depends combinationally on out_ready.
module alu_issue_stage #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter bit FWD_EN  = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [RADDR_W-1:0] rs1_addr,
    input  logic [RADDR_W-1:0] rs2_addr,
    input  logic [XLEN-1:0]    rs1_data,
    input  logic [XLEN-1:0]    rs2_data,
    input  logic [XLEN-1:0]    imm,
    input  logic               use_imm,
    input  logic [2:0]         funct3,
    input  logic               funct7_5,
    input  logic [RADDR_W-1:0] rd_in,
    input  logic               fwd_valid,
    input  logic [RADDR_W-1:0] fwd_rd,
    input  logic [XLEN-1:0]    fwd_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    io_a,
    output logic [XLEN-1:0]    io_b,
    output logic [5:0]         io_opcode,
    output logic [RADDR_W-1:0] rd_out
);
    logic [XLEN-1:0]    n_a, n_b, b_sel, s_a, s_b;
    logic [5:0]         n_op, s_op;
    logic [RADDR_W-1:0] s_rd;
    logic               s_valid, fwd1, fwd2, alt, accept, drain;

    assign fwd1   = FWD_EN && fwd_valid && fwd_rd == rs1_addr && rs1_addr != '0;
    assign fwd2   = FWD_EN && fwd_valid && fwd_rd == rs2_addr && rs2_addr != '0;
    assign n_a    = fwd1 ? fwd_data : rs1_data;
    assign b_sel  = use_imm ? imm : fwd2 ? fwd_data : rs2_data;
    // funct3 001/101 are the shifts: only the 5-bit shamt reaches the ALU
    assign n_b    = funct3[1:0] == 2'b01 ? {{(XLEN-5){1'b0}}, b_sel[4:0]} : b_sel;
    assign alt    = funct3 == 3'b000 ? funct7_5 & ~use_imm : funct3 == 3'b101 ? funct7_5 : 1'b0;
    assign n_op   = {2'b00, funct3, alt};
    assign in_ready = ~s_valid;
    assign accept = in_valid & in_ready;
    assign drain  = ~out_valid | out_ready;

    // skid only fills while main is held, so s_valid implies out_valid
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            s_valid   <= 1'b0;
            io_a      <= '0;
            io_b      <= '0;
            io_opcode <= '0;
            rd_out    <= '0;
            s_a       <= '0;
            s_b       <= '0;
            s_op      <= '0;
            s_rd      <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            s_valid   <= 1'b0;
        end else if (drain) begin
            out_valid <= s_valid | accept;
            s_valid   <= 1'b0;
            if (s_valid) begin
                io_a      <= s_a;
                io_b      <= s_b;
                io_opcode <= s_op;
                rd_out    <= s_rd;
            end else if (accept) begin
                io_a      <= n_a;
                io_b      <= n_b;
                io_opcode <= n_op;
                rd_out    <= rd_in;
            end
        end else if (accept) begin
            s_valid <= 1'b1;
            s_a     <= n_a;
            s_b     <= n_b;
            s_op    <= n_op;
            s_rd    <= rd_in;
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed vector table for operand/opcode encoding plus hand
// sequences for backpressure, flush and asynchronous reset of the skid buffer.
module tb_alu_issue_stage;
    logic        clock = 1'b0, reset, flush, in_valid, in_ready, use_imm, funct7_5;
    logic        fwd_valid, out_valid, out_ready;
    logic [4:0]  rs1_addr, rs2_addr, rd_in, fwd_rd, rd_out;
    logic [31:0] rs1_data, rs2_data, imm, fwd_data, io_a, io_b;
    logic [2:0]  funct3;
    logic [5:0]  io_opcode;
    int          n_cmp = 0, n_fail = 0;

    typedef struct {
        logic [4:0]  r1, r2;
        logic [31:0] d1, d2, im;
        logic        ui;
        logic [2:0]  f3;
        logic        f7, fv;
        logic [4:0]  frd;
        logic [31:0] fd, ea, eb;
        logic [5:0]  eop;
    } vec_t;
    vec_t tv[15];

    alu_issue_stage dut (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .imm(imm), .use_imm(use_imm), .funct3(funct3), .funct7_5(funct7_5), .rd_in(rd_in),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .out_valid(out_valid),
        .out_ready(out_ready), .io_a(io_a), .io_b(io_b), .io_opcode(io_opcode), .rd_out(rd_out)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(logic [4:0] r1, logic [4:0] r2, logic [31:0] d1, logic [31:0] d2,
                                logic [31:0] im, logic ui, logic [2:0] f3, logic f7, logic fv,
                                logic [4:0] frd, logic [31:0] fd, logic [31:0] ea, logic [31:0] eb,
                                logic [5:0] eop);
        vec_t v;
        v.r1 = r1; v.r2 = r2; v.d1 = d1; v.d2 = d2; v.im = im; v.ui = ui; v.f3 = f3; v.f7 = f7;
        v.fv = fv; v.frd = frd; v.fd = fd; v.ea = ea; v.eb = eb; v.eop = eop;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic op(input logic [31:0] a, input logic f7);
        rs1_addr = 5'd1; rs1_data = a; rs2_addr = 5'd2; rs2_data = 32'd1; imm = '0;
        use_imm = 1'b0; funct3 = 3'b000; funct7_5 = f7; fwd_valid = 1'b0; fwd_rd = '0;
        fwd_data = '0; rd_in = 5'd9; in_valid = 1'b1;
    endtask

    initial begin
        tv[0]  = mk(1, 2, 5, 7, 0, 0, 3'b000, 1, 0, 0, 0, 5, 7, 1);
        tv[1]  = mk(1, 2, 5, 7, 7, 1, 3'b000, 1, 0, 0, 0, 5, 7, 0);
        tv[2]  = mk(1, 2, 9, 7, 32'h423, 1, 3'b101, 1, 0, 0, 0, 9, 3, 11);
        tv[3]  = mk(3, 4, 32'h11, 32'h22, 0, 0, 3'b000, 0, 1, 3, 32'hDEADBEEF, 32'hDEADBEEF, 32'h22, 0);
        tv[4]  = mk(0, 4, 32'h11, 32'h22, 0, 0, 3'b000, 0, 1, 0, 32'hDEADBEEF, 32'h11, 32'h22, 0);
        tv[5]  = mk(1, 3, 32'h11, 32'h22, 0, 0, 3'b110, 0, 1, 3, 32'hDEADBEEF, 32'h11, 32'hDEADBEEF, 12);
        tv[6]  = mk(1, 3, 32'h11, 32'h22, 32'h55, 1, 3'b111, 0, 1, 3, 32'hDEADBEEF, 32'h11, 32'h55, 14);
        tv[7]  = mk(1, 2, 32'h80000000, 32'hFFFFFFE3, 0, 0, 3'b001, 1, 0, 0, 0, 32'h80000000, 3, 2);
        tv[8]  = mk(1, 2, 32'h80000000, 32'h25, 0, 0, 3'b101, 0, 0, 0, 0, 32'h80000000, 5, 10);
        tv[9]  = mk(1, 2, 32'h80000000, 32'h1F, 0, 0, 3'b101, 1, 0, 0, 0, 32'h80000000, 32'h1F, 11);
        tv[10] = mk(1, 2, 3, 4, 0, 0, 3'b010, 1, 0, 0, 0, 3, 4, 4);
        tv[11] = mk(1, 2, 3, 4, 0, 0, 3'b011, 1, 0, 0, 0, 3, 4, 6);
        tv[12] = mk(1, 2, 3, 4, 0, 0, 3'b100, 1, 0, 0, 0, 3, 4, 8);
        tv[13] = mk(1, 2, 32'h66, 32'h77, 0, 0, 3'b000, 0, 0, 1, 32'hDEADBEEF, 32'h66, 32'h77, 0);
        tv[14] = mk(5, 5, 1, 2, 0, 0, 3'b111, 0, 1, 5, 32'hCAFE, 32'hCAFE, 32'hCAFE, 14);

        reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
        op(0, 0);
        in_valid = 1'b0;
        #1;
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst in_ready", 32'(in_ready), 1);
        chk("rst io_opcode", 32'(io_opcode), 0);
        chk("rst io_a", io_a, 0);
        @(negedge clock);
        reset = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            rs1_addr = tv[i].r1; rs2_addr = tv[i].r2; rs1_data = tv[i].d1; rs2_data = tv[i].d2;
            imm = tv[i].im; use_imm = tv[i].ui; funct3 = tv[i].f3; funct7_5 = tv[i].f7;
            fwd_valid = tv[i].fv; fwd_rd = tv[i].frd; fwd_data = tv[i].fd;
            rd_in = 5'(i + 1); in_valid = 1'b1;
            @(negedge clock);
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 1);
            chk($sformatf("v%0d io_a", i), io_a, tv[i].ea);
            chk($sformatf("v%0d io_b", i), io_b, tv[i].eb);
            chk($sformatf("v%0d io_opcode", i), 32'(io_opcode), 32'(tv[i].eop));
            chk($sformatf("v%0d rd_out", i), 32'(rd_out), i + 1);
        end
        in_valid = 1'b0;
        @(negedge clock);
        chk("drain out_valid", 32'(out_valid), 0);

        out_ready = 1'b0;
        op(32'hA, 0);
        @(negedge clock);
        chk("bp A valid", 32'(out_valid), 1);
        chk("bp A io_a", io_a, 32'hA);
        chk("bp ready1", 32'(in_ready), 1);
        op(32'hB, 0);
        @(negedge clock);
        chk("bp ready0", 32'(in_ready), 0);
        chk("bp A hold", io_a, 32'hA);
        op(32'hC, 0);
        repeat (2) @(negedge clock);
        chk("bp A stall", io_a, 32'hA);
        chk("bp ready stall", 32'(in_ready), 0);
        out_ready = 1'b1;
        @(negedge clock);
        chk("bp B io_a", io_a, 32'hB);
        chk("bp B valid", 32'(out_valid), 1);
        chk("bp ready back", 32'(in_ready), 1);
        @(negedge clock);
        chk("bp C io_a", io_a, 32'hC);
        in_valid = 1'b0;
        @(negedge clock);
        chk("bp empty", 32'(out_valid), 0);

        out_ready = 1'b0;
        op(32'h31, 0);
        @(negedge clock);
        op(32'h32, 0);
        @(negedge clock);
        chk("fl full", 32'(in_ready), 0);
        op(32'hD, 0);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0; in_valid = 1'b0;
        chk("fl out_valid", 32'(out_valid), 0);
        chk("fl in_ready", 32'(in_ready), 1);
        out_ready = 1'b1;
        repeat (2) @(negedge clock);
        chk("fl D dropped", 32'(out_valid), 0);

        out_ready = 1'b0;
        op(32'h41, 1);
        @(negedge clock);
        op(32'h42, 1);
        @(negedge clock);
        in_valid = 1'b0;
        chk("ar full", 32'(in_ready), 0);
        chk("ar op held", 32'(io_opcode), 1);
        #2 reset = 1'b0;
        #1;
        chk("ar out_valid", 32'(out_valid), 0);
        chk("ar in_ready", 32'(in_ready), 1);
        chk("ar io_opcode", 32'(io_opcode), 0);
        chk("ar io_a", io_a, 0);
        @(negedge clock);
        reset = 1'b1; out_ready = 1'b1;
        @(negedge clock);
        chk("ar stays empty", 32'(out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
